// File: rtl/bp_tethered_dram_model_pkg.sv
// BedRock memory message types and block sizing shared by the tethered DRAM model.
package bp_tethered_dram_model_pkg;

    localparam int unsigned paddr_width_p     = 40;
    localparam int unsigned cce_block_width_p = 512;
    localparam int unsigned word_width_lp     = 64;
    localparam int unsigned block_words_lp    = cce_block_width_p / word_width_lp;

    typedef enum logic [3:0] {
        e_bedrock_mem_rd    = 4'b0000,
        e_bedrock_mem_wr    = 4'b0001,
        e_bedrock_mem_uc_rd = 4'b0010,
        e_bedrock_mem_uc_wr = 4'b0011,
        e_bedrock_mem_pre   = 4'b0100,
        e_bedrock_mem_amo   = 4'b0101
    } bp_bedrock_mem_type_e;

    typedef enum logic [2:0] {
        e_bedrock_msg_size_1  = 3'b000,
        e_bedrock_msg_size_2  = 3'b001,
        e_bedrock_msg_size_4  = 3'b010,
        e_bedrock_msg_size_8  = 3'b011,
        e_bedrock_msg_size_16 = 3'b100,
        e_bedrock_msg_size_32 = 3'b101,
        e_bedrock_msg_size_64 = 3'b110
    } bp_bedrock_msg_size_e;

    typedef struct packed {
        logic [7:0]               payload;
        bp_bedrock_msg_size_e     size;
        logic [paddr_width_p-1:0] addr;
        bp_bedrock_mem_type_e     msg_type;
    } bp_bedrock_cce_mem_header_s;

    typedef struct packed {
        logic [cce_block_width_p-1:0] data;
        bp_bedrock_cce_mem_header_s   header;
    } bp_bedrock_cce_mem_msg_s;

    localparam int unsigned cce_mem_msg_width_lp = $bits(bp_bedrock_cce_mem_msg_s);

endpackage

// File: rtl/bp_tethered_dram_model_mem.sv
// Single-port synchronous RAM with per-byte write enables; read data appears the cycle after the address.
module bp_tethered_dram_model_mem #(
    parameter int unsigned width_p      = 64,
    parameter int unsigned els_p        = 4096,
    parameter int unsigned addr_width_p = (els_p > 1) ? $clog2(els_p) : 1
) (
    input  logic                    clk_i,
    input  logic                    v_i,
    input  logic                    w_i,
    input  logic [addr_width_p-1:0] addr_i,
    input  logic [width_p-1:0]      data_i,
    input  logic [width_p/8-1:0]    write_mask_i,
    output logic [width_p-1:0]      data_o
);

    logic [width_p-1:0] rd_word;
    logic [width_p-1:0] data_q, data_d;

    // Each byte lane is its own array so masked writes never touch neighbouring bytes.
    for (genvar g = 0; g < int'(width_p / 8); g++) begin : g_lane
        logic [7:0] lane_q [els_p];

        always_ff @(posedge clk_i) begin
            if (v_i && w_i && write_mask_i[g]) begin
                lane_q[addr_i] <= data_i[g*8 +: 8];
            end
        end

        assign rd_word[g*8 +: 8] = lane_q[addr_i];
    end

    always_comb begin
        data_d = data_q;
        if (v_i && !w_i) begin
            data_d = rd_word;
        end
    end

    always_ff @(posedge clk_i) begin
        data_q <= data_d;
    end

    assign data_o = data_q;

endmodule

// File: rtl/bp_tethered_dram_model.sv
// DRAM endpoint: accepts one BedRock memory command, waits a fixed latency, services it beat by beat, returns the response.
module bp_tethered_dram_model
    import bp_tethered_dram_model_pkg::*;
#(
    parameter int unsigned mem_els_p = 4096,
    parameter int unsigned latency_p = 8
) (
    input  logic                            clk_i,
    input  logic                            reset_n_i,
    input  logic [cce_mem_msg_width_lp-1:0] mem_cmd_i,
    input  logic                            mem_cmd_v_i,
    output logic                            mem_cmd_ready_o,
    output logic [cce_mem_msg_width_lp-1:0] mem_resp_o,
    output logic                            mem_resp_v_o,
    input  logic                            mem_resp_yumi_i
);

    localparam int unsigned idx_width_lp  = (mem_els_p > 1) ? $clog2(mem_els_p) : 1;
    localparam int unsigned lat_width_lp  = (latency_p > 1) ? $clog2(latency_p) : 1;
    localparam int unsigned slot_width_lp = $clog2(block_words_lp);
    localparam int unsigned beat_width_lp = slot_width_lp + 1;

    typedef enum logic [1:0] {
        e_idle,
        e_wait,
        e_exec,
        e_resp
    } state_e;

    function automatic logic [beat_width_lp-1:0] size_to_beats(input bp_bedrock_msg_size_e size);
        if (size <= e_bedrock_msg_size_8) begin
            return beat_width_lp'(1);
        end
        return beat_width_lp'(32'd1 << (32'(size) - 32'd3));
    endfunction

    function automatic logic [7:0] byte_mask(input bp_bedrock_msg_size_e size, input logic [2:0] off);
        logic [7:0] m;
        case (size)
            e_bedrock_msg_size_1: m = 8'h01 << off;
            e_bedrock_msg_size_2: m = 8'h03 << off;
            e_bedrock_msg_size_4: m = 8'h0F << off;
            default:              m = 8'hFF;
        endcase
        return m;
    endfunction

    function automatic logic [cce_block_width_p-1:0] replicate_sub(
        input logic [63:0] word, input bp_bedrock_msg_size_e size, input logic [2:0] off);
        logic [63:0] val;
        val = word >> {off, 3'b000};
        case (size)
            e_bedrock_msg_size_1: return {(cce_block_width_p / 8){val[7:0]}};
            e_bedrock_msg_size_2: return {(cce_block_width_p / 16){val[15:0]}};
            e_bedrock_msg_size_4: return {(cce_block_width_p / 32){val[31:0]}};
            default:              return {(cce_block_width_p / 64){val}};
        endcase
    endfunction

    state_e                       state_q, state_d;
    bp_bedrock_cce_mem_msg_s      cmd_q, cmd_d;
    logic [cce_block_width_p-1:0] rd_buf_q, rd_buf_d;
    logic [lat_width_lp-1:0]      lat_q, lat_d;
    logic [beat_width_lp-1:0]     beat_q, beat_d;

    logic [beat_width_lp-1:0]     n_beats, last_beat;
    logic [slot_width_lp-1:0]     slot, prev_slot, last_slot;
    logic                         sub_word, is_rd, is_wr;
    logic [2:0]                   byte_off;
    logic                         mem_v, mem_w;
    logic [idx_width_lp-1:0]      mem_addr;
    logic [63:0]                  mem_wdata, mem_rdata;
    logic [7:0]                   mem_mask;
    logic [cce_block_width_p-1:0] resp_data;

    assign n_beats   = size_to_beats(cmd_q.header.size);
    assign last_beat = n_beats - 1'b1;
    assign last_slot = last_beat[slot_width_lp-1:0];
    assign slot      = beat_q[slot_width_lp-1:0];
    assign prev_slot = slot - 1'b1;
    assign sub_word  = cmd_q.header.size < e_bedrock_msg_size_8;
    assign byte_off  = cmd_q.header.addr[2:0];
    assign is_rd     = cmd_q.header.msg_type inside {e_bedrock_mem_rd, e_bedrock_mem_uc_rd};
    assign is_wr     = cmd_q.header.msg_type inside {e_bedrock_mem_wr, e_bedrock_mem_uc_wr};

    always_comb begin
        state_d         = state_q;
        cmd_d           = cmd_q;
        rd_buf_d        = rd_buf_q;
        lat_d           = lat_q;
        beat_d          = beat_q;
        mem_v           = 1'b0;
        mem_w           = 1'b0;
        mem_addr        = cmd_q.header.addr[3 +: idx_width_lp] + idx_width_lp'(beat_q);
        mem_wdata       = sub_word ? (cmd_q.data[63:0] << {byte_off, 3'b000})
                                   : cmd_q.data[{slot, 6'b000000} +: 64];
        mem_mask        = byte_mask(cmd_q.header.size, byte_off);
        resp_data       = '0;
        mem_cmd_ready_o = 1'b0;
        mem_resp_v_o    = 1'b0;
        mem_resp_o      = '0;

        case (state_q)
            e_idle: begin
                mem_cmd_ready_o = reset_n_i;
                if (mem_cmd_v_i) begin
                    cmd_d    = bp_bedrock_cce_mem_msg_s'(mem_cmd_i);
                    rd_buf_d = '0;
                    lat_d    = lat_width_lp'(latency_p - 1);
                    beat_d   = '0;
                    state_d  = e_wait;
                end
            end
            e_wait: begin
                if (lat_q == '0) begin
                    beat_d  = '0;
                    state_d = e_exec;
                end else begin
                    lat_d = lat_q - 1'b1;
                end
            end
            e_exec: begin
                mem_v = is_rd | is_wr;
                mem_w = is_wr;
                // RAM output this cycle belongs to the previous beat's address.
                if (is_rd && (beat_q != '0)) begin
                    rd_buf_d[{prev_slot, 6'b000000} +: 64] = mem_rdata;
                end
                if (beat_q == last_beat) begin
                    state_d = e_resp;
                end else begin
                    beat_d = beat_q + 1'b1;
                end
            end
            e_resp: begin
                mem_resp_v_o = 1'b1;
                // Last beat is taken straight from the RAM, which holds its output while idle.
                if (is_rd) begin
                    if (sub_word) begin
                        resp_data = replicate_sub(mem_rdata, cmd_q.header.size, byte_off);
                    end else begin
                        resp_data = rd_buf_q;
                        resp_data[{last_slot, 6'b000000} +: 64] = mem_rdata;
                    end
                end
                mem_resp_o = {resp_data, cmd_q.header};
                if (mem_resp_yumi_i) begin
                    beat_d  = '0;
                    state_d = e_idle;
                end
            end
            default: state_d = e_idle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_q  <= e_idle;
            cmd_q    <= '0;
            rd_buf_q <= '0;
            lat_q    <= '0;
            beat_q   <= '0;
        end else begin
            state_q  <= state_d;
            cmd_q    <= cmd_d;
            rd_buf_q <= rd_buf_d;
            lat_q    <= lat_d;
            beat_q   <= beat_d;
        end
    end

    bp_tethered_dram_model_mem #(
        .width_p (64),
        .els_p   (mem_els_p)
    ) u_mem (
        .clk_i        (clk_i),
        .v_i          (mem_v),
        .w_i          (mem_w),
        .addr_i       (mem_addr),
        .data_i       (mem_wdata),
        .write_mask_i (mem_mask),
        .data_o       (mem_rdata)
    );

endmodule

// File: tb/tb_bp_tethered_dram_model.sv
// Directed, table-driven bench for bp_tethered_dram_model with hand-computed responses.
module tb_bp_tethered_dram_model;
    import bp_tethered_dram_model_pkg::*;

    localparam int unsigned LAT = 8;
    localparam int unsigned ELS = 4096;

    logic                            clk = 1'b0;
    logic                            reset_n;
    logic [cce_mem_msg_width_lp-1:0] cmd;
    logic                            cmd_v;
    logic                            cmd_ready;
    logic [cce_mem_msg_width_lp-1:0] resp;
    logic                            resp_v;
    logic                            yumi;

    always #5 clk = ~clk;

    bp_tethered_dram_model #(
        .mem_els_p (ELS),
        .latency_p (LAT)
    ) dut (
        .clk_i           (clk),
        .reset_n_i       (reset_n),
        .mem_cmd_i       (cmd),
        .mem_cmd_v_i     (cmd_v),
        .mem_cmd_ready_o (cmd_ready),
        .mem_resp_o      (resp),
        .mem_resp_v_o    (resp_v),
        .mem_resp_yumi_i (yumi)
    );

    typedef struct {
        bp_bedrock_mem_type_e t;
        bp_bedrock_msg_size_e size;
        logic [39:0]          addr;
        logic [511:0]         wdata;
        logic [511:0]         exp;
        int unsigned          cmp_bytes;
        int unsigned          exp_lat;
    } vec_t;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    task automatic check(input string name, input logic [511:0] got, input logic [511:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic vec_t mk(input bp_bedrock_mem_type_e t, input bp_bedrock_msg_size_e size,
                                input logic [39:0] addr, input logic [511:0] wdata,
                                input logic [511:0] exp, input int unsigned cmp_bytes,
                                input int unsigned exp_lat);
        vec_t v;
        v.t = t; v.size = size; v.addr = addr; v.wdata = wdata;
        v.exp = exp; v.cmp_bytes = cmp_bytes; v.exp_lat = exp_lat;
        return v;
    endfunction

    function automatic bp_bedrock_cce_mem_header_s mk_hdr(input vec_t v, input logic [7:0] tag);
        bp_bedrock_cce_mem_header_s h;
        h.payload = tag; h.size = v.size; h.addr = v.addr; h.msg_type = v.t;
        return h;
    endfunction

    // Drive a command in the current cycle (cycle 0) and wait for the response to become valid.
    task automatic issue(input vec_t v, input logic [7:0] tag, output int unsigned lat,
                         output bp_bedrock_cce_mem_msg_s r);
        bp_bedrock_cce_mem_msg_s m;
        m.header = mk_hdr(v, tag);
        m.data   = v.wdata;
        check("ready_idle", 512'(cmd_ready), 512'(1));
        cmd   = m;
        cmd_v = 1'b1;
        @(posedge clk); #1;
        cmd_v = 1'b0;
        cmd   = '0;
        lat   = 1;
        check("ready_busy", 512'(cmd_ready), 512'(0));
        while (!resp_v && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        r = resp;
    endtask

    vec_t                       vecs [16];
    logic [511:0]               blk_a, blk_w, blk_a16, mask;
    bp_bedrock_cce_mem_msg_s    r, held;
    int unsigned                lat;
    int unsigned                stray_v;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        blk_a = '0;
        blk_w = '0;
        for (int k = 7; k >= 0; k--) begin
            blk_a = (blk_a << 64) | 512'(64'h1111_1111_1111_1111 * 64'(k));
            blk_w = (blk_w << 64) | 512'(64'hC0DE_0000_0000_0000 + 64'(k));
        end
        blk_a16 = {384'b0, 64'h3333_3333_3333_3333, 64'h2222_2222_2222_2222};

        vecs[0]  = mk(e_bedrock_mem_wr,    e_bedrock_msg_size_64, 40'h80_0000_0040, blk_a, '0,    64, 17);
        vecs[1]  = mk(e_bedrock_mem_rd,    e_bedrock_msg_size_64, 40'h80_0000_0040, '0,    blk_a, 64, 17);
        vecs[2]  = mk(e_bedrock_mem_rd,    e_bedrock_msg_size_16, 40'h80_0000_0050, '0,    blk_a16, 16, 11);
        vecs[3]  = mk(e_bedrock_mem_uc_wr, e_bedrock_msg_size_8,  40'h100, 512'(64'hFFFF_FFFF_FFFF_FFFF), '0, 64, 10);
        vecs[4]  = mk(e_bedrock_mem_uc_wr, e_bedrock_msg_size_1,  40'h103, 512'(64'h5555_5555_5555_55AB), '0, 64, 10);
        vecs[5]  = mk(e_bedrock_mem_uc_rd, e_bedrock_msg_size_8,  40'h100, '0, 512'(64'hFFFF_FFFF_ABFF_FFFF), 8, 10);
        vecs[6]  = mk(e_bedrock_mem_uc_rd, e_bedrock_msg_size_1,  40'h103, '0, {64{8'hAB}}, 64, 10);
        vecs[7]  = mk(e_bedrock_mem_uc_wr, e_bedrock_msg_size_2,  40'h106, 512'(64'h7777_7777_7777_1234), '0, 64, 10);
        vecs[8]  = mk(e_bedrock_mem_uc_rd, e_bedrock_msg_size_4,  40'h104, '0, {16{32'h1234_FFFF}}, 64, 10);
        vecs[9]  = mk(e_bedrock_mem_pre,   e_bedrock_msg_size_8,  40'h100, 512'(64'h0BAD_0BAD_0BAD_0BAD), '0, 64, 10);
        vecs[10] = mk(e_bedrock_mem_rd,    e_bedrock_msg_size_8,  40'h100, '0, 512'(64'h1234_FFFF_ABFF_FFFF), 8, 10);
        vecs[11] = mk(e_bedrock_mem_wr,    e_bedrock_msg_size_64, 40'h7FE0, blk_w, '0, 64, 17);
        vecs[12] = mk(e_bedrock_mem_uc_rd, e_bedrock_msg_size_8,  40'h0,    '0, 512'(64'hC0DE_0000_0000_0004), 8, 10);
        vecs[13] = mk(e_bedrock_mem_rd,    e_bedrock_msg_size_64, 40'h7FE0, '0, blk_w, 64, 17);
        vecs[14] = mk(e_bedrock_mem_uc_rd, e_bedrock_msg_size_8,  40'h7FF8, '0, 512'(64'hC0DE_0000_0000_0003), 8, 10);
        vecs[15] = mk(e_bedrock_mem_uc_rd, e_bedrock_msg_size_8,  40'h8000, '0, 512'(64'hC0DE_0000_0000_0004), 8, 10);

        reset_n = 1'b0;
        cmd     = '0;
        cmd_v   = 1'b0;
        yumi    = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
            check("rst_ready", 512'(cmd_ready), 512'(0));
            check("rst_resp_v", 512'(resp_v), 512'(0));
            check("rst_resp_zero", 512'(resp == '0), 512'(1));
        end
        reset_n = 1'b1;
        #1;
        check("ready_after_rst", 512'(cmd_ready), 512'(1));
        check("resp_v_after_rst", 512'(resp_v), 512'(0));

        for (int i = 0; i < 16; i++) begin
            issue(vecs[i], 8'h30 + 8'(i), lat, r);
            mask = (512'd1 << (vecs[i].cmp_bytes * 8)) - 512'd1;
            check($sformatf("latency[%0d]", i), 512'(lat), 512'(vecs[i].exp_lat));
            check($sformatf("header[%0d]", i), 512'(r.header), 512'(mk_hdr(vecs[i], 8'h30 + 8'(i))));
            check($sformatf("data[%0d]", i), r.data & mask, vecs[i].exp & mask);
            yumi = 1'b1;
            @(posedge clk); #1;
            yumi = 1'b0;
            check($sformatf("ready_after_yumi[%0d]", i), 512'(cmd_ready), 512'(1));
            check($sformatf("v_after_yumi[%0d]", i), 512'(resp_v), 512'(0));
        end

        // Backpressure: response held for 20 cycles, yumi on the 21st.
        issue(vecs[1], 8'hB0, lat, held);
        check("bp_latency", 512'(lat), 512'(17));
        check("bp_data", held.data, blk_a);
        for (int c = 1; c <= 20; c++) begin
            check($sformatf("bp_stable[%0d]", c), 512'(resp == held), 512'(1));
            check($sformatf("bp_ready_low[%0d]", c), 512'(cmd_ready), 512'(0));
            @(posedge clk); #1;
        end
        check("bp_v_cycle21", 512'(resp_v), 512'(1));
        check("bp_stable_cycle21", 512'(resp == held), 512'(1));
        yumi = 1'b1;
        @(posedge clk); #1;
        yumi = 1'b0;
        check("bp_ready_cycle22", 512'(cmd_ready), 512'(1));

        // Reset during WAIT: the pending write is dropped and never responds.
        check("rw_ready_idle", 512'(cmd_ready), 512'(1));
        cmd   = {512'(64'h0), mk_hdr(vecs[3], 8'hC0)};
        cmd_v = 1'b1;
        @(posedge clk); #1;
        cmd_v = 1'b0;
        cmd   = '0;
        repeat (2) begin @(posedge clk); #1; end
        reset_n = 1'b0;
        @(posedge clk); #1;
        check("rw_ready_in_rst", 512'(cmd_ready), 512'(0));
        reset_n = 1'b1;
        #1;
        check("rw_ready_after_rst", 512'(cmd_ready), 512'(1));
        stray_v = 0;
        repeat (30) begin
            @(posedge clk); #1;
            if (resp_v) stray_v++;
        end
        check("rw_no_response", 512'(stray_v), 512'(0));
        issue(vecs[10], 8'hC1, lat, r);
        check("rw_next_latency", 512'(lat), 512'(10));
        check("rw_next_data", 512'(r.data[63:0]), 512'(64'h1234_FFFF_ABFF_FFFF));
        yumi = 1'b1;
        @(posedge clk); #1;
        yumi = 1'b0;
        check("rw_next_ready", 512'(cmd_ready), 512'(1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
